// File: rtl/agc_alu.sv
// agc_alu: ones'-complement 15-bit ALU for the guidance-computer datapath.
// AD, SU, MASK and the reserved command complete in one clock. MP and DV run
// as a 14-step sequencer (shift-add multiply, restoring divide) on operand
// magnitudes. The result is registered.
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   synchronous, active-high reset
//   A, B     in   16-bit memory words: data [15:1] (bit 15 = sign), parity [0] unused
//   command  in   0=AD 1=SU 2=MASK 3=MP0 4=MP1 5=DV0 6=DV1 7=reserved
//   res      out  registered ones'-complement result
module agc_alu (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic [2:0]  command,
  output logic [14:0] res
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [2:0] CmdAd   = 3'd0;
  localparam logic [2:0] CmdSu   = 3'd1;
  localparam logic [2:0] CmdMask = 3'd2;
  localparam logic [2:0] CmdMp0  = 3'd3;
  localparam logic [2:0] CmdMp1  = 3'd4;
  localparam logic [2:0] CmdDv0  = 3'd5;
  localparam logic [2:0] CmdDv1  = 3'd6;

  logic [14:0] a, b;
  logic        unused_parity;

  assign a = A[15:1];
  assign b = B[15:1];
  assign unused_parity = A[0] ^ B[0];

  logic [1:0]  state_q, state_d;
  logic [3:0]  step_q, step_d;
  logic [2:0]  cmd_q, cmd_d;
  logic [14:0] a_q, a_d, b_q, b_d;
  logic [27:0] acc_q, acc_d;  // MP: product; DV: {remainder, quotient}
  logic [14:0] res_q, res_d;

  function automatic logic is_multi(input logic [2:0] c);
    return (c >= CmdMp0) && (c <= CmdDv1);
  endfunction

  function automatic logic is_div(input logic [2:0] c);
    return (c == CmdDv0) || (c == CmdDv1);
  endfunction

  function automatic logic [13:0] mag(input logic [14:0] x);
    return x[14] ? ~x[13:0] : x[13:0];
  endfunction

  // Single-cycle add/subtract with end-around carry; -0 folded to +0.
  logic [14:0] add_rhs, sum_eac, alu_sum;
  logic [15:0] sum_raw;

  always_comb begin
    add_rhs = (command == CmdSu) ? ~a : a;
    sum_raw = {1'b0, b} + {1'b0, add_rhs};
    sum_eac = sum_raw[14:0] + {14'b0, sum_raw[15]};
    alu_sum = (sum_eac == 15'h7fff) ? 15'h0000 : sum_eac;
  end

  // One sequencer step on the latched operands.
  logic [13:0] mag_a_q, mag_b_q;
  logic [27:0] mp_next, partial;
  logic [14:0] r_sh, r_new;
  logic        div_ge;
  logic [27:0] dv_next;

  always_comb begin
    mag_a_q = mag(a_q);
    mag_b_q = mag(b_q);
    partial = mag_a_q[step_q] ? ({14'b0, mag_b_q} << step_q) : 28'b0;
    mp_next = acc_q + partial;
    r_sh    = {acc_q[27:14], acc_q[13]};
    div_ge  = r_sh >= {1'b0, mag_a_q};
    r_new   = div_ge ? (r_sh - {1'b0, mag_a_q}) : r_sh;
    dv_next = {r_new[13:0], acc_q[12:0], div_ge};
  end

  // Half selection from the stored result; zero magnitude always returns +0.
  logic [13:0] half_mag;
  logic        half_sgn;
  logic [14:0] half_res;

  always_comb begin
    half_sgn = a_q[14] ^ b_q[14];
    half_mag = acc_q[13:0];
    unique case (command)
      CmdMp1:  half_mag = acc_q[27:14];
      CmdDv0: begin
        half_mag = acc_q[27:14];
        half_sgn = b_q[14];
      end
      default: half_mag = acc_q[13:0];
    endcase
    if (half_mag == 14'd0) half_res = 15'h0000;
    else half_res = {half_sgn, half_sgn ? ~half_mag : half_mag};
  end

  logic restart;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cmd_d   = cmd_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    res_d   = res_q;
    // MP0<->MP1 or DV0<->DV1 with the same operands reuses the stored result.
    restart = (state_q == StIdle) || (a != a_q) || (b != b_q) ||
              (is_div(command) != is_div(cmd_q));

    if (!is_multi(command)) begin
      state_d = StIdle;
      step_d  = 4'd0;
      case (command)
        CmdAd, CmdSu: res_d = alu_sum;
        CmdMask:      res_d = a & b;
        default:      res_d = 15'h0000;
      endcase
    end else begin
      cmd_d = command;
      if (restart) begin
        a_d     = a;
        b_d     = b;
        state_d = StRun;
        step_d  = 4'd0;
        acc_d   = is_div(command) ? {14'b0, mag(b)} : 28'b0;
      end else begin
        case (state_q)
          StRun: begin
            acc_d  = is_div(cmd_q) ? dv_next : mp_next;
            step_d = step_q + 4'd1;
            if (step_q == 4'd13) begin
              state_d = StDone;
              step_d  = 4'd0;
            end
          end
          StDone:  res_d   = half_res;
          default: state_d = StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      step_q  <= 4'd0;
      cmd_q   <= 3'd0;
      a_q     <= 15'd0;
      b_q     <= 15'd0;
      acc_q   <= 28'd0;
      res_q   <= 15'd0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cmd_q   <= cmd_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
    end
  end

  assign res = res_q;

endmodule

// File: tb/tb_agc_alu.sv
// Self-checking bench for agc_alu: directed cases plus randomized commands
// compared against an arithmetic reference model (mod 2^15-1 ones'-complement).
module tb_agc_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] A, B;
  logic [2:0]  command;
  logic [14:0] res;

  int n_checks = 0;
  int n_errors = 0;

  agc_alu dut (
    .clk     (clk),
    .reset   (reset),
    .A       (A),
    .B       (B),
    .command (command),
    .res     (res)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [14:0] got, input logic [14:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: res=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic int mag(input logic [14:0] x);
    return x[14] ? (32767 - int'(x)) : int'(x);
  endfunction

  function automatic logic [14:0] enc(input logic s, input int m);
    if (m == 0) return 15'h0000;
    return s ? 15'(32767 - m) : 15'(m);
  endfunction

  function automatic logic [14:0] model(input logic [2:0] c, input logic [14:0] a,
                                        input logic [14:0] b);
    int     ai, bi, ma, mb, q, rm;
    longint p;
    logic   s;
    ai = int'(a);
    bi = int'(b);
    ma = mag(a);
    mb = mag(b);
    s  = a[14] ^ b[14];
    p  = longint'(ma) * longint'(mb);
    if (ma == 0) begin
      q  = 16383;
      rm = mb;
    end else begin
      q  = mb / ma;
      rm = mb % ma;
    end
    case (c)
      3'd0:    return 15'((ai + bi) % 32767);
      3'd1:    return 15'((bi + (32767 - ai)) % 32767);
      3'd2:    return a & b;
      3'd3:    return enc(s, int'(p % 16384));
      3'd4:    return enc(s, int'(p / 16384));
      3'd5:    return enc(b[14], rm);
      3'd6:    return enc(s, q);
      default: return 15'h0000;
    endcase
  endfunction

  task automatic drive(input logic [2:0] c, input logic [14:0] a, input logic [14:0] b);
    @(negedge clk);
    command = c;
    A = {a, 1'($urandom_range(0, 1))};
    B = {b, 1'($urandom_range(0, 1))};
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Apply a command and check after its latency (1 or 16 edges).
  task automatic run_op(input string tag, input logic [2:0] c, input logic [14:0] a,
                        input logic [14:0] b);
    drive(c, a, b);
    wait_edges((c >= 3'd3 && c <= 3'd6) ? 16 : 1);
    check(tag, res, model(c, a, b));
  endtask

  function automatic logic [14:0] pick();
    case ($urandom_range(0, 5))
      0:       return 15'h0000;
      1:       return 15'h7fff;
      2:       return 15'($urandom_range(0, 20));
      3:       return 15'(32767 - $urandom_range(1, 20));
      default: return 15'($urandom);
    endcase
  endfunction

  initial begin
    logic [2:0]  c, c2;
    logic [14:0] a, b;

    reset   = 1'b1;
    command = 3'd0;
    A       = 16'h0000;
    B       = 16'h0000;
    wait_edges(2);
    check("reset", res, 15'h0000);
    @(negedge clk);
    reset = 1'b0;

    // Directed cases
    run_op("ad_4_4", 3'd0, 15'd4, 15'd4);
    run_op("ad_neg0", 3'd0, 15'd4, 15'h7ffb);
    run_op("su_m8", 3'd1, 15'd4, 15'h7ffb);
    run_op("su_m1", 3'd1, 15'd4, 15'd3);
    @(negedge clk);
    command = 3'd2;
    A = 16'hfffe;
    B = 16'heeee;
    wait_edges(1);
    check("mask_7777", res, 15'h7777);
    @(negedge clk);
    A = 16'heeee;
    B = 16'h1110;
    wait_edges(1);
    check("mask_zero", res, 15'h0000);
    run_op("rsvd", 3'd7, 15'h1234, 15'h0555);

    run_op("mp0_12", 3'd3, 15'd4, 15'd3);
    check("mp0_12_const", res, 15'd12);
    drive(3'd4, 15'd4, 15'd3);
    wait_edges(1);
    check("mp1_reuse", res, 15'h0000);
    run_op("mp0_neg", 3'd3, 15'h7ffb, 15'd3);
    check("mp0_neg_const", res, 15'h7ff3);
    drive(3'd4, 15'h7ffb, 15'd3);
    wait_edges(1);
    check("mp1_neg_reuse", res, 15'h0000);

    // Hold during RUN, then new result within 16 edges
    run_op("mp0_pre", 3'd3, 15'd4, 15'd3);
    drive(3'd3, 15'd4, 15'd5);
    wait_edges(5);
    check("hold_run", res, 15'd12);
    wait_edges(11);
    check("mp0_20", res, 15'd20);
    wait_edges(3);
    check("mp0_stable", res, 15'd20);

    run_op("dv1_5", 3'd6, 15'd2, 15'd10);
    drive(3'd5, 15'd2, 15'd10);
    wait_edges(1);
    check("dv0_reuse", res, 15'h0000);
    run_op("dv1_div0", 3'd6, 15'd0, 15'd10);
    check("dv1_div0_const", res, 15'h3fff);
    run_op("dv0_div0", 3'd5, 15'd0, 15'd10);
    check("dv0_div0_const", res, 15'd10);

    // Change A mid-DV: result must reflect the new divisor
    drive(3'd6, 15'd2, 15'd10);
    wait_edges(6);
    drive(3'd6, 15'd3, 15'd10);
    wait_edges(16);
    check("dv_abort", res, 15'd3);

    // Reset mid-MP
    drive(3'd3, 15'd100, 15'd77);
    wait_edges(5);
    @(negedge clk);
    reset = 1'b1;
    wait_edges(1);
    check("reset_mid_mp", res, 15'h0000);
    @(negedge clk);
    reset = 1'b0;
    run_op("mp_after_reset", 3'd3, 15'd100, 15'd77);

    // Randomized commands against the reference model
    for (int i = 0; i < 80; i++) begin
      c = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      run_op("rand", c, a, b);
      if (c >= 3'd3 && c <= 3'd6) begin
        c2 = (c == 3'd3) ? 3'd4 : (c == 3'd4) ? 3'd3 : (c == 3'd5) ? 3'd6 : 3'd5;
        drive(c2, a, b);
        wait_edges(1);
        check("rand_half", res, model(c2, a, b));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
